// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the ALU arbiter slice.
// Holds requester count, width, op type and FSM state type.
package alu_arb_pkg;
    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int IDW       = 2;

    typedef logic [2:0] op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;
endpackage

// File: rtl/alu_arb_if.sv
// Request, shared-ALU and response bundle for alu_arbiter.
// slave: arbiter side; master: requester/ALU/consumer side.
interface alu_arb_if
    import alu_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    op_t                   alu_op;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [WIDTH-1:0]      alu_y;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_ready;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_y, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_y
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_y, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational requester picker: round-robin after last_grant,
// or lowest index first when ALU_ARB_FIXED_PRIO_EN is defined.
// Ports: valid, last_grant in; grant (one-hot), idx, any out.
module rr_pick
    import alu_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_grant;

    always_comb begin
        idx = '0;
        // Descending scan so the lowest valid index is written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[i]) idx = IDW'(i);
        end
    end
`else
    logic [IDW-1:0] k;

    always_comb begin
        idx = '0;
        k   = '0;
        // Walk offsets NREQ..1 so the nearest one after last_grant wins;
        // offset NREQ is last_grant itself, hence lowest priority.
        for (int i = NREQ; i >= 1; i--) begin
            k = IDW'((int'(last_grant) + i) % NREQ);
            if (valid[k]) idx = k;
        end
    end
`endif

    assign any = |valid;

    always_comb begin
        grant = '0;
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters (IDLE/EXEC/RESP).
// Ports: clk, rst_n, bus (alu_arb_if.slave). Option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_arb_if.slave bus
);
    state_t           state;
    state_t           state_n;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   gidx;
    logic [NREQ-1:0]  gnt;
    logic             any;
    logic             hs;
    logic             done;
    op_t              op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .grant      (gnt),
        .idx        (gidx),
        .any        (any)
    );

    // Gated by rst_n so ready drops the instant reset asserts.
    assign bus.req_ready = (state == IDLE && rst_n) ? gnt : '0;

    assign hs   = any & |(bus.req_valid & bus.req_ready);
    assign done = bus.rsp_valid & bus.rsp_ready;

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                op_sel = bus.req_op[3*i +: 3];
                a_sel  = bus.req_a[WIDTH*i +: WIDTH];
                b_sel  = bus.req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (hs) state_n = EXEC;
            EXEC:    state_n = RESP;
            RESP:    if (done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= IDW'(NREQ - 1);
            bus.alu_op    <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_y     <= '0;
            bus.rsp_valid <= 1'b0;
        end else begin
            if (hs) begin
                bus.alu_op <= op_sel;
                bus.alu_a  <= a_sel;
                bus.alu_b  <= b_sel;
                bus.rsp_id <= gidx;
                last_grant <= gidx;
            end
            if (state == EXEC) begin
                bus.rsp_y     <= bus.alu_y;
                bus.rsp_valid <= 1'b1;
            end else if (done) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter.
// Transaction-level reference: grant rule, ALU function, response timing.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arb_if #(.NREQ(4), .WIDTH(8)) bus ();

    alu_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] alu_fn(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return ~a;
        endcase
    endfunction

    assign bus.alu_y = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

    int n_vec = 0;
    int n_err = 0;
    int m_last = 3;

    logic [2:0] op_r [4];
    logic [7:0] a_r  [4];
    logic [7:0] b_r  [4];

    function automatic int exp_grant(logic [3:0] v, int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
        for (int i = 1; i <= 4; i++) if (v[(last + i) % 4]) return (last + i) % 4;
`endif
        return -1;
    endfunction

    task automatic randomize_ops();
        for (int k = 0; k < 4; k++) begin
            op_r[k] = 3'($urandom_range(0, 7));
            a_r[k]  = 8'($urandom);
            b_r[k]  = 8'($urandom);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            bus.req_op[3*k +: 3] = op_r[k];
            bus.req_a[8*k +: 8]  = a_r[k];
            bus.req_b[8*k +: 8]  = b_r[k];
        end
        bus.req_valid = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 3;
    endtask

    task automatic test_reset();
        randomize_ops();
        drive(4'b1111);
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL rst req_ready got %b want 0000", bus.req_ready); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL rst rsp_id got %0d want 0", bus.rsp_id); end
        n_vec++; if (bus.rsp_y !== 8'd0) begin n_err++; $display("FAIL rst rsp_y got %h want 00", bus.rsp_y); end
        n_vec++; if (bus.alu_op !== 3'd0) begin n_err++; $display("FAIL rst alu_op got %0d want 0", bus.alu_op); end
        n_vec++; if (bus.alu_a !== 8'd0) begin n_err++; $display("FAIL rst alu_a got %h want 00", bus.alu_a); end
        n_vec++; if (bus.alu_b !== 8'd0) begin n_err++; $display("FAIL rst alu_b got %h want 00", bus.alu_b); end
        @(negedge clk);
        drive(4'b0000);
        rst_n = 1'b1;
        m_last = 3;
        @(negedge clk);
        n_vec++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL idle req_ready got %b want 0000", bus.req_ready); end
    endtask

    task automatic test_single();
        @(negedge clk);
        randomize_ops();
        op_r[0] = 3'b010; a_r[0] = 8'h0F; b_r[0] = 8'h03;
        drive(4'b0001);
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single ready got %b want 0001", bus.req_ready); end
        @(negedge clk);
        drive(4'b0000);
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single early rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'b010, 8'h0F, 8'h03}) begin
            n_err++; $display("FAIL single alu regs got %0d/%h/%h want 2/0f/03", bus.alu_op, bus.alu_a, bus.alu_b); end
        @(negedge clk);
        n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single rsp_valid got %b want 1", bus.rsp_valid); end
        n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL single rsp_id got %0d want 0", bus.rsp_id); end
        n_vec++; if (bus.rsp_y !== 8'h03) begin n_err++; $display("FAIL single rsp_y got %h want 03", bus.rsp_y); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single rsp clear got %b want 0", bus.rsp_valid); end
        m_last = 0;
    endtask

    task automatic test_rr_seq(input logic [3:0] v, input int n);
        int e;
        bit seen;
        randomize_ops();
        drive(v);
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < n; t++) begin
            e = exp_grant(v, m_last);
            seen = 0;
            for (int c = 0; c < 6 && !seen; c++) begin
                @(negedge clk);
                if (bus.rsp_valid === 1'b1) seen = 1;
            end
            n_vec++;
            if (!seen) begin
                n_err++; $display("FAIL seq %b timeout rsp %0d", v, t);
            end else begin
                if (bus.rsp_id !== 2'(e)) begin n_err++; $display("FAIL seq %b id got %0d want %0d", v, bus.rsp_id, e); end
                n_vec++;
                if (bus.rsp_y !== alu_fn(op_r[e], a_r[e], b_r[e])) begin
                    n_err++; $display("FAIL seq %b y got %h want %h", v, bus.rsp_y, alu_fn(op_r[e], a_r[e], b_r[e])); end
                n_vec++;
                if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL seq %b ready in resp got %b want 0000", v, bus.req_ready); end
            end
            m_last = e;
        end
        @(negedge clk);
        drive(4'b0000);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] ey;
        @(negedge clk);
        randomize_ops();
        drive(4'b0100);
        #1;
        n_vec++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL bp ready got %b want 0100", bus.req_ready); end
        ey = alu_fn(op_r[2], a_r[2], b_r[2]);
        @(negedge clk);
        drive(4'b0000);
        @(negedge clk);
        drive(4'b1111);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.req_ready} !== {1'b1, 2'd2, ey, 4'b0}) begin
                n_err++; $display("FAIL bp hold c%0d got v%b id%0d y%h r%b want v1 id2 y%h r0000",
                    c, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.req_ready, ey);
            end
            @(negedge clk);
        end
        drive(4'b0000);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp accept rsp_valid got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp second accept rsp_valid got 1 want 0"); end
        m_last = 2;
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        randomize_ops();
        a_r[1] = 8'hA5; op_r[1] = 3'd3;
        drive(4'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.alu_op, bus.alu_a, bus.alu_b, bus.req_ready} !== '0) begin
            n_err++; $display("FAIL rst exec got v%b id%0d y%h op%0d a%h b%h r%b want all zero",
                bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.alu_op, bus.alu_a, bus.alu_b, bus.req_ready);
        end
        @(negedge clk);
        drive(4'b0000);
        rst_n = 1'b1;
        m_last = 3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst exec ghost rsp c%0d got 1 want 0", c); end
        end
    endtask

    task automatic test_random(input int n);
        logic [3:0] v;
        int e, hold;
        logic [2:0] eop;
        logic [7:0] ea, eb, ey;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            randomize_ops();
            v = 4'($urandom_range(1, 15));
            drive(v);
            e = exp_grant(v, m_last);
            eop = op_r[e]; ea = a_r[e]; eb = b_r[e];
            ey = alu_fn(eop, ea, eb);
            #1;
            n_vec++; if (bus.req_ready !== 4'(1 << e)) begin n_err++; $display("FAIL rnd%0d grant v%b got %b want %0d", t, v, bus.req_ready, e); end
            @(negedge clk);
            randomize_ops();
            drive(4'($urandom_range(0, 15)));
            #1;
            n_vec++;
            if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.req_ready} !== {eop, ea, eb, 1'b0, 4'b0}) begin
                n_err++; $display("FAIL rnd%0d exec got op%0d a%h b%h v%b r%b want op%0d a%h b%h v0 r0000",
                    t, bus.alu_op, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.req_ready, eop, ea, eb);
            end
            @(negedge clk);
            hold = $urandom_range(0, 3);
            for (int c = 0; c <= hold; c++) begin
                n_vec++;
                if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.req_ready, bus.alu_op, bus.alu_a, bus.alu_b}
                    !== {1'b1, 2'(e), ey, 4'b0, eop, ea, eb}) begin
                    n_err++; $display("FAIL rnd%0d resp got v%b id%0d y%h r%b want v1 id%0d y%h r0000",
                        t, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.req_ready, e, ey);
                end
                if (c == hold) bus.rsp_ready = 1'b1;
                @(negedge clk);
            end
            bus.rsp_ready = 1'b0;
            drive(4'b0000);
            n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d rsp clear got 1 want 0", t); end
            m_last = e;
        end
    endtask

    initial begin
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        test_reset();
        test_single();
        pulse_reset();
        test_rr_seq(4'b1111, 5);
        pulse_reset();
        test_rr_seq(4'b1010, 3);
        test_backpressure();
        test_reset_exec();
        test_random(40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the ALU (fixed at 4 in this release).
REQ-002 Parameter WIDTH, default 8, operand/result width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_op  input  3*NREQ  per-requester ALU op select, slice [3k+2:3k] for requester k.
REQ-008 req_a, req_b  input  WIDTH*NREQ  per-requester operands, slice [WIDTH*k+WIDTH-1:WIDTH*k].
REQ-009 alu_op  output  3  op select driven to the shared combinational ALU.
REQ-010 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-011 alu_y  input  WIDTH  combinational ALU result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_id  output  2  index of requester owning rsp_y.
REQ-014 rsp_y  output  WIDTH  registered result.
REQ-015 rsp_ready  input  1  consumer accepts result.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 IDLE: if any req_valid, SHALL compute grant g combinationally and assert req_ready[g] only; else stay IDLE with req_ready=0.
REQ-018 Handshake req_valid[g]&req_ready[g] SHALL capture op/a/b of g into alu_op/alu_a/alu_b registers, g into rsp_id, last_grant<=g, go EXEC.
REQ-019 EXEC (one cycle): SHALL register alu_y into rsp_y, set rsp_valid=1, go RESP.
REQ-020 RESP: SHALL hold rsp_valid, rsp_id, rsp_y stable until rsp_ready=1; on rsp_valid&rsp_ready SHALL clear rsp_valid and go IDLE the next cycle.
REQ-021 req_ready SHALL be 0 in EXEC and RESP; latency handshake->rsp_valid = 2 cycles; max throughput one op per 3 cycles.
REQ-022 Round-robin: grant SHALL search from (last_grant+1) mod NREQ upward with wrap; requester just served has lowest priority.
REQ-023 alu_op/alu_a/alu_b SHALL hold their last captured values outside handshake cycles.
REQ-024 Simultaneous req_valid on all requesters SHALL be served 0,1,2,3,0... with no starvation.
REQ-025 A requester dropping req_valid before handshake SHALL not be granted; grant re-evaluated each IDLE cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, last_grant=NREQ-1, rsp_valid=0, rsp_id=0, rsp_y=0, alu_op=0, alu_a=0, alu_b=0, req_ready=0.
REQ-027 Reset mid-EXEC/RESP SHALL discard the in-flight operation; no result is emitted after release.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: grant SHALL be lowest-index valid requester (0 highest), last_grant ignored for selection.
REQ-029 Macro undefined: round-robin per REQ-022.

Structure
REQ-030 Package alu_arb_pkg SHALL hold NREQ, WIDTH defaults, 3-bit op typedef, FSM state typedef.
REQ-031 Sub-module rr_pick SHALL implement the combinational priority/round-robin picker (inputs valid vector, last_grant; outputs one-hot grant, index, any).

Verification
REQ-032 Reset then req_valid=4'b0001, op=3'b010, a=8'h0F, b=8'h03 -> req_ready=4'b0001 same cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_y=alu_y sampled in EXEC.
REQ-033 req_valid=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 (with ALU_ARB_FIXED_PRIO_EN: 0,0,0,0).
REQ-034 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_y/rsp_id stable, req_ready=0 throughout, then single accept.
REQ-035 req_valid=4'b1010 after last_grant=3 -> grant 1, then 3, then 1.
REQ-036 rst_n pulled low in EXEC -> all outputs zero immediately; after release no rsp_valid until a new handshake.
